// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from an internal byte FIFO.
// Bit timing comes from an external baud generator gated by bps_en.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              clk_uart,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              TX_FIFO_FULL,
    output logic              TX_FIFO_EMPTY,
    output logic              TXD,
    output logic              bps_en,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic              txd_nxt;
    logic              done_nxt;

    // A push while full is dropped even if a pop frees a slot in the same clk.
    assign push = wr_en && !TX_FIFO_FULL;
    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            TX_FIFO_FULL  <= 1'b0;
            TX_FIFO_EMPTY <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count         <= count_nxt;
            TX_FIFO_FULL  <= (count_nxt == DEPTH_C);
            TX_FIFO_EMPTY <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            shift   <= '1;
            bit_cnt <= '0;
            TXD     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            TXD     <= txd_nxt;
            tx_done <= done_nxt;
        end
    end

    // TXD is registered: each branch sets the level for the bit that begins next clk.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        txd_nxt     = TXD;
        done_nxt    = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (!TX_FIFO_EMPTY) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (clk_uart) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    txd_nxt     = shift[0];
                end
            end
            DATA: begin
                if (clk_uart) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        shift_nxt   = {1'b1, shift[DATA_W-1:1]};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        txd_nxt     = shift[1];
                    end
                end
            end
            STOP: begin
                if (clk_uart) begin
                    done_nxt = 1'b1;
                    // Chain straight into the next start bit so bps_en never drops.
                    if (!TX_FIFO_EMPTY) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                        txd_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    assign bps_en  = (state == START) || (state == DATA) || (state == STOP);
    assign tx_busy = (state != IDLE);

endmodule
